frame_buffer_manager: RTL
=========================

// Module: frame_buffer_manager
// PURPOSE
//  Parametrised N-buffer (2..4) DDR frame-buffer arbiter; replaces the fixed writer/reader buf_select swap.
//  Tracks write (W), read (R) and pending-complete (P) buffer indices and issues the base addresses for the
//  AXI4 writer and reader. Swaps the display buffer only at output vsync, so the picture never tears.
//  N>=3 gives triple buffering, where the writer never stalls. N=2 gives double buffering with writer stall.
// PARAMETERS
//  NUM_BUFS     3              number of frame buffers, legal 2..4
//  BASE_ADDR    32'h1000_0000  DDR address of buffer 0
//  FRAME_BYTES  32'h0009_6000  stride between buffers (640x480x16bpp)
//  CNT_W        16             width of the drop and repeat counters
// PORTS
//  clk_100Mhz     in   1        AXI/system clock
//  rst            in   1        async reset, active-high
//  wr_frame_done  in   1        1-cycle pulse: writer finished the frame in W (clk_100Mhz domain)
//  rd_vsync       in   1        vsync_start level from the 25 MHz VTG domain (asynchronous)
//  freeze         in   1        1 = hold the current display buffer (suppress swaps)
//  wr_buf_idx     out  IDX_W    buffer the writer fills; IDX_W = clog2(NUM_BUFS)
//  rd_buf_idx     out  IDX_W    buffer the reader scans out
//  wr_base_addr   out  32       BASE_ADDR + wr_buf_idx*FRAME_BYTES
//  rd_base_addr   out  32       BASE_ADDR + rd_buf_idx*FRAME_BYTES
//  wr_stall       out  1        writer must not start a new frame (N=2 only)
//  new_frame      out  1        1-cycle pulse: rd_buf_idx changed
//  drop_cnt       out  CNT_W    completed frames discarded unread (saturating)
//  repeat_cnt     out  CNT_W    vsyncs with no new frame to show (saturating)
// BEHAVIOUR
//  Reset values: W=0, R=NUM_BUFS-1, P_valid=0, wr_stall=0, new_frame=0, counters=0.
//   Base addresses match these indices. All outputs are registered.
//  Vsync path: 2-flop synchroniser, then rising-edge detect, giving vs_pulse.
//   vs_pulse is high on the 3rd clk edge after rd_vsync is first sampled high.
//   Indices and addresses update on the following edge.
//  Each cycle, next state is computed in this order: (1) frame_done, (2) vs_pulse.
//   Both steps use the results of step 1.
//  (1) wr_frame_done, N>=3:
//   - if P_valid: old P is discarded and drop_cnt++.
//   - P<=W, P_valid<=1.
//   - W<=lowest index not equal to R_next and not equal to P_next.
//  (1) wr_frame_done, N=2:
//   - if P_valid (writer stalled): pulse ignored, drop_cnt++, no index change.
//   - else P<=W, P_valid<=1, wr_stall<=1.
//  (2) vs_pulse && !freeze:
//   - if P_valid: R<=P, P_valid<=0, new_frame<=1.
//   - N=2: additionally W<=old R, wr_stall<=0.
//   - if !P_valid: repeat_cnt++ and R unchanged.
//  (2) vs_pulse && freeze: R unchanged, repeat_cnt++.
//   P keeps being replaced per (1); N=2 stays stalled.
//  Simultaneous frame_done + vs_pulse: the just-completed frame is shown at once.
//   R<=old W, P_valid ends 0, no drop. N=3: W<=lowest index != old W.
//  Invariant, checked by assertion: W != R, and W != P and R != P whenever P_valid.
//  Counters saturate at all-ones; they do not wrap.
//  Base address = BASE_ADDR + idx*FRAME_BYTES, 32-bit, computed from constants (shift/add, no DSP).
//   It is registered in the same cycle as the index.
//  Reset mid-frame returns everything to the reset values at once. Resuming the writer is the writer's job.
//  rd_vsync held high gives a single vs_pulse; a new pulse needs a low then high transition.
// STRUCTURE
//  fb_pkg holds:
//   - FRAME_BYTES_VGA16 = 614400.
//   - MAX_BUFS = 4.
//   - function idx_w(n) = clog2 with a minimum of 1.
//   - function buf_addr(base, idx, stride).
//  Sub-module vsync_edge_sync: 2-flop synchroniser plus rising-edge pulse, with async reset.
//   It is reused for any 25 MHz to 100 MHz level.
//  Remainder: one next-state always_comb and one registered always_ff block. There is no FSM beyond the W/R/P
//   state and the stall flag.
// TESTING
//  T1 N=3:
//   - frame_done, then vsync: R goes 2->0, W goes 0->1; new_frame pulses once.
//   - rd_base_addr = 0x1000_0000, wr_base_addr = 0x1009_6000.
//  T2 N=3, 3 frame_done before one vsync: drop_cnt=2, R shows the last completed buffer, invariant holds.
//  T3 N=2:
//   - frame_done: wr_stall=1.
//   - second frame_done: drop_cnt=1, indices unchanged.
//   - vsync: R=0, W=1, wr_stall=0.
//  T4 Same-cycle frame_done and vs_pulse (N=3): R=old W, P_valid=0, drop_cnt unchanged.
//  T5 freeze=1 over 5 vsyncs with frames arriving: R constant, repeat_cnt=5.
//   After freeze=0, the next vsync shows the newest frame.
//  T6 rst pulsed mid-operation (async, between clock edges):
//   - outputs return to reset values before the next edge.
//   - rd_vsync held high over 100 cycles gives exactly 1 swap.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared constants and helpers for the frame-buffer manager.
// Buffer indices are carried at MAX_IDX_W bits internally and narrowed at the ports.
package fb_pkg;

  localparam int unsigned FRAME_BYTES_VGA16 = 614400;
  localparam int unsigned MAX_BUFS          = 4;
  localparam int unsigned MAX_IDX_W         = 2;

  typedef logic [MAX_IDX_W-1:0] buf_idx_t;

  typedef struct packed {
    buf_idx_t w;
    buf_idx_t r;
    buf_idx_t p;
    logic     pv;
    logic     stall;
  } buf_state_t;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Shift/add over the index bits so a constant stride never needs a multiplier.
  function automatic logic [31:0] buf_addr(input logic [31:0] base,
                                           input buf_idx_t    idx,
                                           input logic [31:0] stride);
    logic [31:0] a;
    a = base;
    for (int i = 0; i < int'(MAX_IDX_W); i++) begin
      if (idx[i]) a = a + (stride << i);
    end
    return a;
  endfunction

endpackage

// File: rtl/vsync_edge_sync.sv
// Brings an asynchronous level into clk_100Mhz with two flops and emits a
// registered one-cycle pulse on its rising edge.
module vsync_edge_sync (
  input  logic clk_100Mhz,
  input  logic rst,
  input  logic level_i,
  output logic pulse_o
);

  logic sync1_q, sync2_q, prev_q, pulse_q;
  logic pulse_d;

  assign pulse_d = sync2_q & ~prev_q;

  always_ff @(posedge clk_100Mhz or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= level_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      pulse_q <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/frame_buffer_manager.sv
// N-buffer (2..4) DDR frame-buffer arbiter: tracks write/read/pending buffers and
// issues base addresses; the display buffer only swaps on output vsync.
module frame_buffer_manager
  import fb_pkg::*;
#(
  parameter int unsigned NUM_BUFS    = 3,
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter logic [31:0] FRAME_BYTES = 32'h0009_6000,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                           clk_100Mhz,
  input  logic                           rst,
  input  logic                           wr_frame_done_i,
  input  logic                           rd_vsync_i,
  input  logic                           freeze_i,
  output logic [idx_w(NUM_BUFS)-1:0]     wr_buf_idx_o,
  output logic [idx_w(NUM_BUFS)-1:0]     rd_buf_idx_o,
  output logic [31:0]                    wr_base_addr_o,
  output logic [31:0]                    rd_base_addr_o,
  output logic                           wr_stall_o,
  output logic                           new_frame_o,
  output logic [CNT_W-1:0]               drop_cnt_o,
  output logic [CNT_W-1:0]               repeat_cnt_o
);

  localparam int unsigned IDX_W = idx_w(NUM_BUFS);
  localparam buf_idx_t    R_RST = buf_idx_t'(NUM_BUFS - 1);

  buf_state_t       st_q, st_d;
  logic [CNT_W-1:0] drop_q, drop_d, rep_q, rep_d;
  logic             nf_q, nf_d;
  logic [31:0]      wr_addr_q, rd_addr_q;
  logic             vs_pulse;
  logic             drop_inc, rep_inc;

  vsync_edge_sync u_vs_sync (
    .clk_100Mhz (clk_100Mhz),
    .rst        (rst),
    .level_i    (rd_vsync_i),
    .pulse_o    (vs_pulse)
  );

  function automatic buf_idx_t lowest_free(input buf_idx_t r, input buf_idx_t p, input logic pv);
    buf_idx_t sel;
    sel = '0;
    for (int i = int'(NUM_BUFS) - 1; i >= 0; i--) begin
      if (buf_idx_t'(i) != r && !(pv && buf_idx_t'(i) == p)) sel = buf_idx_t'(i);
    end
    return sel;
  endfunction

  // Frame-done is resolved first; the vsync step then acts on that result, so a
  // frame finishing on the vsync cycle is displayed immediately.
  always_comb begin
    st_d     = st_q;
    drop_d   = drop_q;
    rep_d    = rep_q;
    nf_d     = 1'b0;
    drop_inc = 1'b0;
    rep_inc  = 1'b0;

    if (wr_frame_done_i) begin
      if (NUM_BUFS == 2) begin
        if (st_q.pv) begin
          drop_inc = 1'b1;
        end else begin
          st_d.p     = st_q.w;
          st_d.pv    = 1'b1;
          st_d.stall = 1'b1;
        end
      end else begin
        drop_inc = st_q.pv;
        st_d.p   = st_q.w;
        st_d.pv  = 1'b1;
      end
    end

    if (vs_pulse) begin
      if (!freeze_i && st_d.pv) begin
        st_d.r  = st_d.p;
        st_d.pv = 1'b0;
        nf_d    = 1'b1;
        if (NUM_BUFS == 2) begin
          st_d.w     = st_q.r;
          st_d.stall = 1'b0;
        end
      end else begin
        rep_inc = 1'b1;
      end
    end

    if (NUM_BUFS != 2 && wr_frame_done_i) begin
      st_d.w = lowest_free(st_d.r, st_d.p, st_d.pv);
    end

    if (drop_inc && drop_q != '1) drop_d = drop_q + 1'b1;
    if (rep_inc && rep_q != '1)   rep_d  = rep_q + 1'b1;
  end

  always_ff @(posedge clk_100Mhz or posedge rst) begin
    if (rst) begin
      st_q.w     <= '0;
      st_q.r     <= R_RST;
      st_q.p     <= '0;
      st_q.pv    <= 1'b0;
      st_q.stall <= 1'b0;
      drop_q     <= '0;
      rep_q      <= '0;
      nf_q       <= 1'b0;
      wr_addr_q  <= BASE_ADDR;
      rd_addr_q  <= buf_addr(BASE_ADDR, R_RST, FRAME_BYTES);
    end else begin
      st_q      <= st_d;
      drop_q    <= drop_d;
      rep_q     <= rep_d;
      nf_q      <= nf_d;
      wr_addr_q <= buf_addr(BASE_ADDR, st_d.w, FRAME_BYTES);
      rd_addr_q <= buf_addr(BASE_ADDR, st_d.r, FRAME_BYTES);
    end
  end

  // With two buffers the stalled writer still points at the pending buffer.
  assert property (@(posedge clk_100Mhz) disable iff (rst)
    (st_q.w != st_q.r) &&
    (!st_q.pv || (st_q.r != st_q.p && (NUM_BUFS == 2 || st_q.w != st_q.p))));

  assign wr_buf_idx_o   = st_q.w[IDX_W-1:0];
  assign rd_buf_idx_o   = st_q.r[IDX_W-1:0];
  assign wr_base_addr_o = wr_addr_q;
  assign rd_base_addr_o = rd_addr_q;
  assign wr_stall_o     = st_q.stall;
  assign new_frame_o    = nf_q;
  assign drop_cnt_o     = drop_q;
  assign repeat_cnt_o   = rep_q;

endmodule
